// File: rtl/icache_ctrl_pkg.sv
// Shared types and constants for the multi-port icache control-bus slave.
// Contents:
//   CNT_W_DEF     - default statistics counter width
//   NB_EVT        - number of statistics event types
//   flush_state_e - full / selective flush sequencer states
//   bypass_state_e- bypass sequencer states
//   evt_idx_e     - index of each event type in the counter arrays
package icache_ctrl_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int NB_EVT    = 4;

    typedef enum logic [2:0] {
        FL_IDLE,
        FL_FLUSH,
        FL_DONE_F,
        FL_SFLUSH,
        FL_DONE_S
    } flush_state_e;

    typedef enum logic [1:0] {
        BP_CACHE,
        BP_ENTER,
        BP_BYP,
        BP_EXIT
    } bypass_state_e;

    typedef enum int {
        EVT_HIT   = 0,
        EVT_TRANS = 1,
        EVT_MISS  = 2,
        EVT_CONG  = 3
    } evt_idx_e;

endpackage

// File: rtl/icache_stat_counter.sv
// Wrapping statistics counter.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - add inc this cycle when high
//   clr       - synchronous clear; wins over en and drops this cycle's inc
//   inc       - amount to add (INC_W bits)
//   count     - current value, wraps modulo 2^CNT_W
module icache_stat_counter #(
    parameter int CNT_W = 32,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CNT_W'(inc);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/mp_icache_ctrl_slave.sv
// Slave-side responder of the multi-port icache control bus.
// Sequences bypass entry/exit over the private core banks and the shared
// bank, runs full and selective flushes across all core banks with 4-phase
// handshakes towards the control unit, and keeps per-bank and global
// hit/trans/miss/cong statistics.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   bypass_req_i / bypass_ack_o      bypass level request / {shared, core} bypass state
//   flush_req_i / flush_ack_o        full flush 4-phase handshake
//   sel_flush_req_i/_addr_i/_ack_o   selective flush 4-phase handshake + line address
//   ctrl_clear_regs_i                clear all statistics counters
//   ctrl_enable_regs_i               statistics counting enable
//   global_*_count_o                 global counters (sum over banks)
//   bank_*_count_o                   per-bank counters, bank i at [i*CNT_W +: CNT_W]
//   bank_*_evt_i                     per-bank single-cycle event pulses
//   core_bypass_req_o/_ack_i         bypass handshake with the core banks
//   shared_bypass_req_o/_ack_i       bypass handshake with the shared bank
//   bank_flush_req_o/_ack_i          per-bank full flush request / ack pulse
//   bank_sel_flush_req_o/_addr_o/_ack_i  per-bank selective flush request / address / ack pulse
module mp_icache_ctrl_slave
    import icache_ctrl_pkg::*;
#(
    parameter int NB_CORES = 8,
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      bypass_req_i,
    output logic [NB_CORES:0]         bypass_ack_o,
    input  logic                      flush_req_i,
    output logic                      flush_ack_o,
    input  logic                      sel_flush_req_i,
    input  logic [ADDR_W-1:0]         sel_flush_addr_i,
    output logic                      sel_flush_ack_o,

    input  logic                      ctrl_clear_regs_i,
    input  logic                      ctrl_enable_regs_i,
    output logic [CNT_W-1:0]          global_hit_count_o,
    output logic [CNT_W-1:0]          global_trans_count_o,
    output logic [CNT_W-1:0]          global_miss_count_o,
    output logic [CNT_W-1:0]          global_cong_count_o,
    output logic [NB_CORES*CNT_W-1:0] bank_hit_count_o,
    output logic [NB_CORES*CNT_W-1:0] bank_trans_count_o,
    output logic [NB_CORES*CNT_W-1:0] bank_miss_count_o,
    output logic [NB_CORES*CNT_W-1:0] bank_cong_count_o,
    input  logic [NB_CORES-1:0]       bank_hit_evt_i,
    input  logic [NB_CORES-1:0]       bank_trans_evt_i,
    input  logic [NB_CORES-1:0]       bank_miss_evt_i,
    input  logic [NB_CORES-1:0]       bank_cong_evt_i,

    output logic [NB_CORES-1:0]       core_bypass_req_o,
    input  logic [NB_CORES-1:0]       core_bypass_ack_i,
    output logic                      shared_bypass_req_o,
    input  logic                      shared_bypass_ack_i,

    output logic [NB_CORES-1:0]       bank_flush_req_o,
    input  logic [NB_CORES-1:0]       bank_flush_ack_i,
    output logic [NB_CORES-1:0]       bank_sel_flush_req_o,
    output logic [ADDR_W-1:0]         bank_sel_flush_addr_o,
    input  logic [NB_CORES-1:0]       bank_sel_flush_ack_i
);

    localparam int POP_W = $clog2(NB_CORES + 1);
    localparam logic [NB_CORES-1:0] ALL_BANKS = {NB_CORES{1'b1}};

    // ------------------------------------------------------------------
    // Flush sequencer
    // ------------------------------------------------------------------
    flush_state_e        flush_state_reg;
    logic [NB_CORES-1:0] bank_flush_req_reg;
    logic [NB_CORES-1:0] bank_sel_flush_req_reg;
    logic [NB_CORES-1:0] done_mask_reg;
    logic [ADDR_W-1:0]   sel_addr_reg;
    logic                flush_ack_reg;
    logic                sel_flush_ack_reg;

    // Only acks against a request bit still outstanding count; duplicates
    // and stray pulses fall out here.
    logic [NB_CORES-1:0] flush_hits;
    logic [NB_CORES-1:0] sel_hits;
    logic [NB_CORES-1:0] flush_done_next;
    logic [NB_CORES-1:0] sel_done_next;

    assign flush_hits      = bank_flush_ack_i & bank_flush_req_reg;
    assign sel_hits        = bank_sel_flush_ack_i & bank_sel_flush_req_reg;
    assign flush_done_next = done_mask_reg | flush_hits;
    assign sel_done_next   = done_mask_reg | sel_hits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_state_reg        <= FL_IDLE;
            bank_flush_req_reg     <= '0;
            bank_sel_flush_req_reg <= '0;
            done_mask_reg          <= '0;
            sel_addr_reg           <= '0;
            flush_ack_reg          <= 1'b0;
            sel_flush_ack_reg      <= 1'b0;
        end else begin
            unique case (flush_state_reg)
                FL_IDLE: begin
                    // Full flush wins; a pending selective flush keeps its
                    // request up and is picked up on a later IDLE cycle.
                    if (flush_req_i) begin
                        flush_state_reg    <= FL_FLUSH;
                        bank_flush_req_reg <= ALL_BANKS;
                        done_mask_reg      <= '0;
                    end else if (sel_flush_req_i) begin
                        flush_state_reg        <= FL_SFLUSH;
                        bank_sel_flush_req_reg <= ALL_BANKS;
                        sel_addr_reg           <= sel_flush_addr_i;
                        done_mask_reg          <= '0;
                    end
                end
                FL_FLUSH: begin
                    bank_flush_req_reg <= bank_flush_req_reg & ~bank_flush_ack_i;
                    done_mask_reg      <= flush_done_next;
                    if (flush_done_next == ALL_BANKS) begin
                        flush_state_reg <= FL_DONE_F;
                        flush_ack_reg   <= 1'b1;
                    end
                end
                FL_DONE_F: begin
                    if (!flush_req_i) begin
                        flush_state_reg <= FL_IDLE;
                        flush_ack_reg   <= 1'b0;
                    end
                end
                FL_SFLUSH: begin
                    bank_sel_flush_req_reg <= bank_sel_flush_req_reg & ~bank_sel_flush_ack_i;
                    done_mask_reg          <= sel_done_next;
                    if (sel_done_next == ALL_BANKS) begin
                        flush_state_reg   <= FL_DONE_S;
                        sel_flush_ack_reg <= 1'b1;
                    end
                end
                FL_DONE_S: begin
                    if (!sel_flush_req_i) begin
                        flush_state_reg   <= FL_IDLE;
                        sel_flush_ack_reg <= 1'b0;
                    end
                end
                default: begin
                    flush_state_reg <= FL_IDLE;
                end
            endcase
        end
    end

    assign bank_flush_req_o      = bank_flush_req_reg;
    assign bank_sel_flush_req_o  = bank_sel_flush_req_reg;
    assign bank_sel_flush_addr_o = sel_addr_reg;
    assign flush_ack_o           = flush_ack_reg;
    assign sel_flush_ack_o       = sel_flush_ack_reg;

    // ------------------------------------------------------------------
    // Bypass sequencer: core banks drain first, then the shared bank;
    // leaving bypass releases the shared bank first, then the cores.
    // ------------------------------------------------------------------
    bypass_state_e       bypass_state_reg;
    logic [NB_CORES-1:0] core_bypass_req_reg;
    logic                shared_bypass_req_reg;
    logic [NB_CORES:0]   bypass_ack_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypass_state_reg      <= BP_CACHE;
            core_bypass_req_reg   <= '0;
            shared_bypass_req_reg <= 1'b0;
            bypass_ack_reg        <= '0;
        end else begin
            bypass_ack_reg <= {shared_bypass_ack_i, core_bypass_ack_i};
            unique case (bypass_state_reg)
                BP_CACHE: begin
                    if (bypass_req_i) begin
                        bypass_state_reg    <= BP_ENTER;
                        core_bypass_req_reg <= ALL_BANKS;
                    end
                end
                BP_ENTER: begin
                    if (!bypass_req_i) begin
                        bypass_state_reg    <= BP_CACHE;
                        core_bypass_req_reg <= '0;
                    end else if (core_bypass_ack_i == ALL_BANKS) begin
                        bypass_state_reg      <= BP_BYP;
                        shared_bypass_req_reg <= 1'b1;
                    end
                end
                BP_BYP: begin
                    if (!bypass_req_i) begin
                        bypass_state_reg      <= BP_EXIT;
                        shared_bypass_req_reg <= 1'b0;
                    end
                end
                BP_EXIT: begin
                    if (!shared_bypass_ack_i) begin
                        if (bypass_req_i) begin
                            // Re-request while exiting: cores are still held,
                            // so go straight back to waiting on their acks.
                            bypass_state_reg <= BP_ENTER;
                        end else begin
                            bypass_state_reg    <= BP_CACHE;
                            core_bypass_req_reg <= '0;
                        end
                    end
                end
                default: begin
                    bypass_state_reg <= BP_CACHE;
                end
            endcase
        end
    end

    assign core_bypass_req_o   = core_bypass_req_reg;
    assign shared_bypass_req_o = shared_bypass_req_reg;
    assign bypass_ack_o        = bypass_ack_reg;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [NB_CORES-1:0] evt      [NB_EVT];
    logic [POP_W-1:0]    pop      [NB_EVT];
    logic [CNT_W-1:0]    bank_cnt [NB_EVT][NB_CORES];
    logic [CNT_W-1:0]    glob_cnt [NB_EVT];

    assign evt[EVT_HIT]   = bank_hit_evt_i;
    assign evt[EVT_TRANS] = bank_trans_evt_i;
    assign evt[EVT_MISS]  = bank_miss_evt_i;
    assign evt[EVT_CONG]  = bank_cong_evt_i;

    always_comb begin
        for (int e = 0; e < NB_EVT; e++) begin
            pop[e] = '0;
            for (int i = 0; i < NB_CORES; i++) begin
                pop[e] = pop[e] + POP_W'(evt[e][i]);
            end
        end
    end

    for (genvar ge = 0; ge < NB_EVT; ge++) begin : g_evt
        for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_bank
            icache_stat_counter #(
                .CNT_W (CNT_W),
                .INC_W (1)
            ) u_bank_cnt (
                .clk   (clk),
                .rst   (rst),
                .en    (ctrl_enable_regs_i),
                .clr   (ctrl_clear_regs_i),
                .inc   (evt[ge][gi]),
                .count (bank_cnt[ge][gi])
            );
        end

        icache_stat_counter #(
            .CNT_W (CNT_W),
            .INC_W (POP_W)
        ) u_glob_cnt (
            .clk   (clk),
            .rst   (rst),
            .en    (ctrl_enable_regs_i),
            .clr   (ctrl_clear_regs_i),
            .inc   (pop[ge]),
            .count (glob_cnt[ge])
        );
    end

    for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_out
        assign bank_hit_count_o  [gi*CNT_W +: CNT_W] = bank_cnt[EVT_HIT][gi];
        assign bank_trans_count_o[gi*CNT_W +: CNT_W] = bank_cnt[EVT_TRANS][gi];
        assign bank_miss_count_o [gi*CNT_W +: CNT_W] = bank_cnt[EVT_MISS][gi];
        assign bank_cong_count_o [gi*CNT_W +: CNT_W] = bank_cnt[EVT_CONG][gi];
    end

    assign global_hit_count_o   = glob_cnt[EVT_HIT];
    assign global_trans_count_o = glob_cnt[EVT_TRANS];
    assign global_miss_count_o  = glob_cnt[EVT_MISS];
    assign global_cong_count_o  = glob_cnt[EVT_CONG];

endmodule

// File: tb/tb_mp_icache_ctrl_slave.sv
// Directed bench for mp_icache_ctrl_slave: 4 core banks, 8-bit counters so
// the wrap boundary is reachable in a few hundred cycles.
module tb_mp_icache_ctrl_slave;

    localparam int NB = 4;
    localparam int AW = 32;
    localparam int CW = 8;

    logic              clk;
    logic              rst;
    logic              bypass_req;
    logic [NB:0]       bypass_ack;
    logic              flush_req;
    logic              flush_ack;
    logic              sel_flush_req;
    logic [AW-1:0]     sel_flush_addr;
    logic              sel_flush_ack;
    logic              clr_regs;
    logic              en_regs;
    logic [CW-1:0]     g_hit, g_trans, g_miss, g_cong;
    logic [NB*CW-1:0]  b_hit, b_trans, b_miss, b_cong;
    logic [NB-1:0]     e_hit, e_trans, e_miss, e_cong;
    logic [NB-1:0]     core_breq;
    logic [NB-1:0]     core_back;
    logic              sh_breq;
    logic              sh_back;
    logic [NB-1:0]     bf_req;
    logic [NB-1:0]     bf_ack;
    logic [NB-1:0]     bsf_req;
    logic [AW-1:0]     bsf_addr;
    logic [NB-1:0]     bsf_ack;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    mp_icache_ctrl_slave #(
        .NB_CORES (NB),
        .ADDR_W   (AW),
        .CNT_W    (CW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .bypass_req_i          (bypass_req),
        .bypass_ack_o          (bypass_ack),
        .flush_req_i           (flush_req),
        .flush_ack_o           (flush_ack),
        .sel_flush_req_i       (sel_flush_req),
        .sel_flush_addr_i      (sel_flush_addr),
        .sel_flush_ack_o       (sel_flush_ack),
        .ctrl_clear_regs_i     (clr_regs),
        .ctrl_enable_regs_i    (en_regs),
        .global_hit_count_o    (g_hit),
        .global_trans_count_o  (g_trans),
        .global_miss_count_o   (g_miss),
        .global_cong_count_o   (g_cong),
        .bank_hit_count_o      (b_hit),
        .bank_trans_count_o    (b_trans),
        .bank_miss_count_o     (b_miss),
        .bank_cong_count_o     (b_cong),
        .bank_hit_evt_i        (e_hit),
        .bank_trans_evt_i      (e_trans),
        .bank_miss_evt_i       (e_miss),
        .bank_cong_evt_i       (e_cong),
        .core_bypass_req_o     (core_breq),
        .core_bypass_ack_i     (core_back),
        .shared_bypass_req_o   (sh_breq),
        .shared_bypass_ack_i   (sh_back),
        .bank_flush_req_o      (bf_req),
        .bank_flush_ack_i      (bf_ack),
        .bank_sel_flush_req_o  (bsf_req),
        .bank_sel_flush_addr_o (bsf_addr),
        .bank_sel_flush_ack_i  (bsf_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        bypass_req = 1'b1; flush_req = 1'b1; sel_flush_req = 1'b1;
        sel_flush_addr = 32'hDEAD_BEEF;
        clr_regs = 1'b0; en_regs = 1'b1;
        e_hit = '0; e_trans = '0; e_miss = '0; e_cong = '0;
        core_back = '0; sh_back = 1'b0;
        bf_ack = '0; bsf_ack = '0;

        // ---- Reset with requests high: outputs clear before any clock edge
        #3 rst = 1'b1;
        #1;
        $display("txn reset: async assert with requests high");
        chk("rst_flush_ack",  64'(flush_ack), 64'h0);
        chk("rst_bf_req",     64'(bf_req),    64'h0);
        chk("rst_core_breq",  64'(core_breq), 64'h0);
        chk("rst_bypass_ack", 64'(bypass_ack),64'h0);
        chk("rst_g_hit",      64'(g_hit),     64'h0);
        chk("rst_b_hit",      64'(b_hit),     64'h0);
        bypass_req = 1'b0; flush_req = 1'b0; sel_flush_req = 1'b0; en_regs = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("idle_sh_breq", 64'(sh_breq), 64'h0);

        // ---- Full flush with staggered and duplicate acks
        $display("txn full flush: staggered acks, duplicate ack on bank2");
        flush_req = 1'b1;
        step();
        chk("ff_req_all", 64'(bf_req), 64'hF);
        bf_ack = 4'b0011; step(); bf_ack = '0;
        chk("ff_req_after01", 64'(bf_req), 64'hC);
        step();
        bf_ack = 4'b0100; step(); bf_ack = '0;
        chk("ff_req_after2", 64'(bf_req), 64'h8);
        bf_ack = 4'b0100; step(); bf_ack = '0;
        chk("ff_dup_ack_req", 64'(bf_req),    64'h8);
        chk("ff_dup_ack_ack", 64'(flush_ack), 64'h0);
        bf_ack = 4'b1000; step(); bf_ack = '0;
        chk("ff_ack_high", 64'(flush_ack), 64'h1);
        chk("ff_req_clear", 64'(bf_req),   64'h0);
        step();
        chk("ff_ack_held", 64'(flush_ack), 64'h1);
        flush_req = 1'b0; step();
        chk("ff_ack_drop", 64'(flush_ack), 64'h0);

        // ---- Simultaneous full and selective flush requests
        $display("txn flush+sel_flush simultaneous, addr 1c008040");
        flush_req = 1'b1; sel_flush_req = 1'b1; sel_flush_addr = 32'h1C00_8040;
        step();
        chk("sim_bf_req",  64'(bf_req),  64'hF);
        chk("sim_bsf_req", 64'(bsf_req), 64'h0);
        bf_ack = 4'hF; step(); bf_ack = '0;
        chk("sim_flush_ack", 64'(flush_ack),     64'h1);
        chk("sim_sel_ack0",  64'(sel_flush_ack), 64'h0);
        flush_req = 1'b0; step();
        chk("sim_flush_ack_drop", 64'(flush_ack), 64'h0);
        step();
        chk("sf_bsf_req",  64'(bsf_req),  64'hF);
        chk("sf_addr",     64'(bsf_addr), 64'h1C00_8040);
        sel_flush_addr = 32'h0000_1234;
        bsf_ack = 4'b0101; step(); bsf_ack = '0;
        chk("sf_req_part",   64'(bsf_req),  64'hA);
        chk("sf_addr_stable",64'(bsf_addr), 64'h1C00_8040);
        bsf_ack = 4'b1010; step(); bsf_ack = '0;
        chk("sf_ack_high", 64'(sel_flush_ack), 64'h1);
        sel_flush_req = 1'b0; step();
        chk("sf_ack_drop", 64'(sel_flush_ack), 64'h0);

        // ---- Bypass entry and exit
        $display("txn bypass on/off");
        bypass_req = 1'b1; step();
        chk("bp_core_req", 64'(core_breq), 64'hF);
        chk("bp_sh_req0",  64'(sh_breq),   64'h0);
        core_back = 4'b0111; step();
        chk("bp_sh_wait", 64'(sh_breq), 64'h0);
        core_back = 4'hF; step();
        chk("bp_sh_req1", 64'(sh_breq), 64'h1);
        sh_back = 1'b1; step();
        chk("bp_ack_all", 64'(bypass_ack), 64'h1F);
        bypass_req = 1'b0; step();
        chk("bpx_sh_req0", 64'(sh_breq),   64'h0);
        chk("bpx_core_hold", 64'(core_breq), 64'hF);
        step();
        chk("bpx_core_hold2", 64'(core_breq), 64'hF);
        sh_back = 1'b0; step();
        chk("bpx_core_drop", 64'(core_breq), 64'h0);
        core_back = '0; step();
        chk("bpx_ack_zero", 64'(bypass_ack), 64'h0);

        // ---- Statistics
        $display("txn stats: disabled miss, hit pattern, trans, clear");
        e_miss = 4'b0001; step(); e_miss = '0;
        chk("st_miss_disabled", 64'(b_miss[CW-1:0]), 64'h0);
        en_regs = 1'b1;
        e_hit = 4'b0011; step(); step();
        e_hit = 4'b0001; step(); step(); step();
        e_hit = 4'b0010; step(); e_hit = '0;
        chk("st_b0_hit", 64'(b_hit[0*CW +: CW]), 64'd5);
        chk("st_b1_hit", 64'(b_hit[1*CW +: CW]), 64'd3);
        chk("st_g_hit",  64'(g_hit),             64'd8);
        e_trans = 4'b1000; step(); e_trans = '0;
        chk("st_b3_trans", 64'(b_trans[3*CW +: CW]), 64'd1);
        chk("st_g_trans",  64'(g_trans),             64'd1);
        clr_regs = 1'b1; e_hit = 4'b0001; step(); clr_regs = 1'b0; e_hit = '0;
        chk("clr_b0_hit",  64'(b_hit[0*CW +: CW]), 64'h0);
        chk("clr_g_hit",   64'(g_hit),             64'h0);
        chk("clr_g_trans", 64'(g_trans),           64'h0);

        // ---- Counter wrap
        $display("txn stats: wrap at 2^CNT_W");
        e_hit = 4'b0001;
        repeat (255) step();
        chk("wrap_b0_max", 64'(b_hit[0*CW +: CW]), 64'hFF);
        chk("wrap_g_max",  64'(g_hit),             64'hFF);
        step(); e_hit = '0;
        chk("wrap_b0_zero", 64'(b_hit[0*CW +: CW]), 64'h0);
        chk("wrap_g_zero",  64'(g_hit),             64'h0);
        en_regs = 1'b0;

        // ---- Abort flush with reset, late ack ignored
        $display("txn abort: rst during flush, late ack");
        flush_req = 1'b1; step();
        chk("ab_req_set", 64'(bf_req), 64'hF);
        #2 rst = 1'b1;
        #1;
        chk("ab_req_cleared", 64'(bf_req), 64'h0);
        flush_req = 1'b0;
        step();
        rst = 1'b0;
        bf_ack = 4'hF; step(); bf_ack = '0;
        chk("ab_late_ack", 64'(flush_ack), 64'h0);
        chk("ab_late_req", 64'(bf_req),    64'h0);
        step();
        chk("ab_idle_ack", 64'(flush_ack), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
